core_issue_ctrl: RTL and testbench
==================================

# core_issue_ctrl

In-order issue controller between the decode stage and the execution units (ALU, load/store unit, FPU). It holds a scoreboard of pending destination writes for the 32 integer and 32 FP registers and stalls decode on RAW, WAW or structural hazards. It issues one instruction per cycle to the selected unit, with at most one outstanding memory op and one outstanding FPU op. Fence, fence.i and I/O instructions drain the pipeline, and fence.i also sequences an instruction-cache invalidate.

## Interface
Parameters:
- NONE; register count is fixed at 32+32, so no parameters are defined.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; synchronous, active-low
- ID_VALID  in  1  decoded instruction present
- ID_READY  out  1  controller accepts the instruction this cycle
- ID_UNIT  in  2  0=ALU, 1=MEM, 2=FPU, 3=SYS
- ID_FENCEI  in  1  SYS instruction is fence.i; fence/in/out otherwise
- ID_RD_NUM, ID_RS1_NUM, ID_RS2_NUM  in  5 each  register numbers
- ID_RDVALID  in  1  instruction writes integer rd
- ID_FRDVALID  in  1  instruction writes FP rd
- ID_USE_RS1, ID_USE_RS2  in  1 each  source is read
- ID_RS1_F, ID_RS2_F  in  1 each  source reads the FP file (0 = integer file)
- ISSUE_ALU, ISSUE_MEM, ISSUE_FPU, ISSUE_SYS  out  1 each  one-cycle issue strobes
- MEM_DONE  in  1  one-cycle pulse: outstanding memory op completed and written back
- FPU_DONE  in  1  one-cycle pulse: outstanding FPU op completed and written back
- IC_INV  out  1  I-cache invalidate request; level signal, held until IC_INV_DONE
- IC_INV_DONE  in  1  one-cycle pulse
- INT_BUSY  out  32  registered integer scoreboard
- FP_BUSY  out  32  registered FP scoreboard
- IDLE  out  1  no pending ops and state RUN

## Operation
- Pending slots:
  - MEM slot and FPU slot each hold {valid, is_fp, rd}.
  - A slot's rd bit is set in the matching busy vector only if the instruction writes a register.
  - An ALU instruction is never tracked (single-cycle, forwarded).
- Integer register 0 is never marked busy; a write to x0 is not tracked. FP f0 is a normal register.
- Effective busy:
  - The same-cycle DONE bypass applies to all busy checks below, including hazard checks and the structural check.
  - Effective busy = registered busy with the bit of a slot whose DONE is asserted this cycle removed.
  - The same applies to slot valid.
- Hazard for an instruction:
  - RAW: any used source is effectively busy in its file.
  - WAW: destination is effectively busy in its file.
  - Structural: unit MEM while the MEM slot is effectively valid; unit FPU while the FPU slot is effectively valid.
- FSM states: RUN, DRAIN, SYNC.
  - RUN: ID_READY = !hazard for ALU/MEM/FPU.
  - RUN, SYS with no effective pending op: issue immediately. Fence.i goes to SYNC; otherwise stay in RUN.
  - RUN, SYS with a pending op: ID_READY=0, go to DRAIN.
  - DRAIN: ID_READY=0 until both slots are effectively empty. In that cycle ID_READY=1 and ISSUE_SYS fires. Fence.i goes to SYNC; otherwise go to RUN.
  - SYNC: IC_INV=1, ID_READY=0. On IC_INV_DONE, go to RUN (ID_READY still 0 that cycle).
- Issue: ISSUE_x = ID_VALID & ID_READY & (ID_UNIT==x). On MEM/FPU issue, the slot is loaded and the busy bit is set at the next edge.
- DONE with no valid slot is ignored. The busy bit is cleared at the same edge as the slot.

## Timing
- Reset values:
  - INT_BUSY = FP_BUSY = 0, both slots invalid, state RUN.
  - IC_INV=0, all ISSUE_*=0, IDLE=1.
  - ID_READY follows combinationally from the reset state.
- ID_READY and ISSUE_* are combinational from ID_* inputs, DONE inputs, state and registers. Decode inputs must be stable while ID_VALID=1.
- Latency: a dependent instruction issues in the same cycle as the producer's DONE pulse.
- Back-to-back: MEM issue at cycle n, MEM_DONE at n+k → a second MEM op can issue at n+k.
- Simultaneous MEM_DONE and FPU_DONE: both slots clear.
- Issue and DONE of the same slot in one cycle: the new entry wins. The old rd bit clears and the new rd bit sets.
- RST_N low mid-operation (including in SYNC) returns to reset values at the next edge. IC_INV drops immediately after that edge.

## Structure
- Package core_pkg holds:
  - unit encoding localparams UNIT_ALU/MEM/FPU/SYS
  - FSM state enum
  - slot typedef {valid, is_fp, rd[4:0]}
- Natural sub-module: core_scoreboard, holding the two 32-bit busy vectors with set/clear ports and bypassed read for hazard checks. The FSM and slots stay in core_issue_ctrl.

## Test plan
- RAW stall: MEM load to x5 issued, then ALU with rs1=x5 → ID_READY=0 until MEM_DONE. On the MEM_DONE cycle ID_READY=1 and ISSUE_ALU=1.
- Cross-file check: FPU op to f3 pending, then ALU reading integer x3 → issues immediately. An FPU op reading f3 stalls.
- x0 write: MEM op to x0 → INT_BUSY stays 0. A following ALU op reading x0 issues while the MEM slot is valid.
- Structural stall: two FPU ops to f1 then f2 → second stalls until FPU_DONE. Simultaneous FPU_DONE with the new issue leaves FP_BUSY=0x4.
- Fence.i drain: MEM and FPU pending, then fence.i → DRAIN. After both DONEs: ISSUE_SYS pulse, then IC_INV=1 for 3 cycles until IC_INV_DONE, then RUN. Next instruction issues one cycle later.
- Reset in SYNC: RST_N low for 1 cycle → IC_INV=0, busy vectors 0, IDLE=1 on the next edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the in-order issue controller: unit encoding,
// controller state, pending-slot layout and a slot-to-busy-mask helper.
package core_pkg;

   localparam logic [1:0] UNIT_ALU = 2'd0;
   localparam logic [1:0] UNIT_MEM = 2'd1;
   localparam logic [1:0] UNIT_FPU = 2'd2;
   localparam logic [1:0] UNIT_SYS = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SYNC  = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       is_fp;
      logic [4:0] rd;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '0;

   // One-hot busy mask owned by a slot in the requested register file.
   // Integer x0 never appears in a mask. A slot whose instruction writes
   // no register is stored as integer rd=0, so it also yields no mask.
   function automatic logic [31:0] slot_mask(input slot_t s, input logic want_fp);
      logic [31:0] m;
      m = '0;
      if (s.valid && (s.is_fp == want_fp)) begin
         m[s.rd] = 1'b1;
      end
      if (!want_fp) begin
         m[0] = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/core_scoreboard.sv
// Pending-write scoreboard for the 32 integer and 32 FP registers.
// Set wins over clear so that an issue and a completion aimed at the same
// register in one cycle leave the register busy for the new producer.
module core_scoreboard
   import core_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] set_int,
   input  logic [31:0] set_fp,
   input  logic [31:0] clr_int,
   input  logic [31:0] clr_fp,
   output logic [31:0] int_busy,
   output logic [31:0] fp_busy,
   output logic [31:0] int_busy_eff,
   output logic [31:0] fp_busy_eff
);

   localparam logic [31:0] INT_KEEP = 32'hFFFF_FFFE;

   // Busy vectors: clear completed writes, then add newly issued ones.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         int_busy <= '0;
         fp_busy  <= '0;
      end else begin
         int_busy <= ((int_busy & ~clr_int) | set_int) & INT_KEEP;
         fp_busy  <= (fp_busy & ~clr_fp) | set_fp;
      end
   end

   // Hazard view: a register completing this cycle is already free.
   always_comb begin
      int_busy_eff = int_busy & ~clr_int;
      fp_busy_eff  = fp_busy & ~clr_fp;
   end

endmodule

// File: rtl/core_issue_ctrl.sv
// In-order issue controller between decode and the ALU / LSU / FPU.
// Tracks one outstanding memory op and one outstanding FPU op, stalls decode
// on RAW, WAW and structural hazards, and drains the pipeline for SYS ops.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | normal issue; SYS issues at once when nothing is pending
//   ST_DRAIN | SYS waiting for both slots to empty, then issues
//   ST_SYNC  | fence.i issued; I-cache invalidate held until acknowledged
module core_issue_ctrl
   import core_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        ID_VALID,
   output logic        ID_READY,
   input  logic [1:0]  ID_UNIT,
   input  logic        ID_FENCEI,
   input  logic [4:0]  ID_RD_NUM,
   input  logic [4:0]  ID_RS1_NUM,
   input  logic [4:0]  ID_RS2_NUM,
   input  logic        ID_RDVALID,
   input  logic        ID_FRDVALID,
   input  logic        ID_USE_RS1,
   input  logic        ID_USE_RS2,
   input  logic        ID_RS1_F,
   input  logic        ID_RS2_F,
   output logic        ISSUE_ALU,
   output logic        ISSUE_MEM,
   output logic        ISSUE_FPU,
   output logic        ISSUE_SYS,
   input  logic        MEM_DONE,
   input  logic        FPU_DONE,
   output logic        IC_INV,
   input  logic        IC_INV_DONE,
   output logic [31:0] INT_BUSY,
   output logic [31:0] FP_BUSY,
   output logic        IDLE
);

   state_t      state;
   state_t      state_nxt;
   slot_t       mem_slot;
   slot_t       fpu_slot;
   slot_t       new_slot;

   logic        mem_clr;
   logic        fpu_clr;
   logic        mem_vld_eff;
   logic        fpu_vld_eff;
   logic        pending_eff;
   logic        is_sys;
   logic        raw_hz;
   logic        waw_hz;
   logic        str_hz;
   logic        hazard;

   logic [31:0] set_int;
   logic [31:0] set_fp;
   logic [31:0] clr_int;
   logic [31:0] clr_fp;
   logic [31:0] int_busy_eff;
   logic [31:0] fp_busy_eff;

   core_scoreboard u_scoreboard (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .set_int      (set_int),
      .set_fp       (set_fp),
      .clr_int      (clr_int),
      .clr_fp       (clr_fp),
      .int_busy     (INT_BUSY),
      .fp_busy      (FP_BUSY),
      .int_busy_eff (int_busy_eff),
      .fp_busy_eff  (fp_busy_eff)
   );

   // Completion bypass: a DONE only counts against a slot that is occupied.
   always_comb begin
      mem_clr     = MEM_DONE & mem_slot.valid;
      fpu_clr     = FPU_DONE & fpu_slot.valid;
      mem_vld_eff = mem_slot.valid & ~MEM_DONE;
      fpu_vld_eff = fpu_slot.valid & ~FPU_DONE;
      pending_eff = mem_vld_eff | fpu_vld_eff;
      clr_int     = (mem_clr ? slot_mask(mem_slot, 1'b0) : '0)
                  | (fpu_clr ? slot_mask(fpu_slot, 1'b0) : '0);
      clr_fp      = (mem_clr ? slot_mask(mem_slot, 1'b1) : '0)
                  | (fpu_clr ? slot_mask(fpu_slot, 1'b1) : '0);
   end

   // Slot image for the decoded instruction; no destination is stored as x0.
   always_comb begin
      new_slot       = SLOT_EMPTY;
      new_slot.valid = 1'b1;
      if (ID_FRDVALID) begin
         new_slot.is_fp = 1'b1;
         new_slot.rd    = ID_RD_NUM;
      end else if (ID_RDVALID) begin
         new_slot.rd    = ID_RD_NUM;
      end
   end

   // Hazard detection against the bypassed busy view.
   always_comb begin
      is_sys = (ID_UNIT == UNIT_SYS);
      raw_hz = (ID_USE_RS1 & (ID_RS1_F ? fp_busy_eff[ID_RS1_NUM] : int_busy_eff[ID_RS1_NUM]))
             | (ID_USE_RS2 & (ID_RS2_F ? fp_busy_eff[ID_RS2_NUM] : int_busy_eff[ID_RS2_NUM]));
      waw_hz = (ID_FRDVALID & fp_busy_eff[ID_RD_NUM])
             | (ID_RDVALID & ~ID_FRDVALID & int_busy_eff[ID_RD_NUM]);
      str_hz = ((ID_UNIT == UNIT_MEM) & mem_vld_eff)
             | ((ID_UNIT == UNIT_FPU) & fpu_vld_eff);
      hazard = raw_hz | waw_hz | str_hz;
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (ID_VALID && is_sys) begin
               if (pending_eff) begin
                  state_nxt = ST_DRAIN;
               end else if (ID_FENCEI) begin
                  state_nxt = ST_SYNC;
               end
            end
         end
         ST_DRAIN: begin
            if (!pending_eff) begin
               state_nxt = (ID_VALID && ID_FENCEI) ? ST_SYNC : ST_RUN;
            end
         end
         ST_SYNC: begin
            if (IC_INV_DONE) begin
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Outputs: handshake, issue strobes and invalidate request.
   always_comb begin
      ID_READY = 1'b0;
      IC_INV   = 1'b0;
      case (state)
         ST_RUN:   ID_READY = is_sys ? ~pending_eff : ~hazard;
         ST_DRAIN: ID_READY = ~pending_eff;
         ST_SYNC:  IC_INV   = 1'b1;
         default:  ID_READY = 1'b0;
      endcase
      ISSUE_ALU = ID_VALID & ID_READY & (ID_UNIT == UNIT_ALU);
      ISSUE_MEM = ID_VALID & ID_READY & (ID_UNIT == UNIT_MEM);
      ISSUE_FPU = ID_VALID & ID_READY & (ID_UNIT == UNIT_FPU);
      ISSUE_SYS = ID_VALID & ID_READY & (ID_UNIT == UNIT_SYS);
      set_int   = (ISSUE_MEM | ISSUE_FPU) ? slot_mask(new_slot, 1'b0) : '0;
      set_fp    = (ISSUE_MEM | ISSUE_FPU) ? slot_mask(new_slot, 1'b1) : '0;
      IDLE      = ~mem_slot.valid & ~fpu_slot.valid & (state == ST_RUN);
   end

   // Pending slots: a new issue overrides a same-cycle completion.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         mem_slot <= SLOT_EMPTY;
         fpu_slot <= SLOT_EMPTY;
      end else begin
         if (ISSUE_MEM) begin
            mem_slot <= new_slot;
         end else if (mem_clr) begin
            mem_slot <= SLOT_EMPTY;
         end
         if (ISSUE_FPU) begin
            fpu_slot <= new_slot;
         end else if (fpu_clr) begin
            fpu_slot <= SLOT_EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed bench for core_issue_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are compared 2 time units after it.
module tb_core_issue_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        ID_VALID;
   logic        ID_READY;
   logic [1:0]  ID_UNIT;
   logic        ID_FENCEI;
   logic [4:0]  ID_RD_NUM;
   logic [4:0]  ID_RS1_NUM;
   logic [4:0]  ID_RS2_NUM;
   logic        ID_RDVALID;
   logic        ID_FRDVALID;
   logic        ID_USE_RS1;
   logic        ID_USE_RS2;
   logic        ID_RS1_F;
   logic        ID_RS2_F;
   logic        ISSUE_ALU;
   logic        ISSUE_MEM;
   logic        ISSUE_FPU;
   logic        ISSUE_SYS;
   logic        MEM_DONE;
   logic        FPU_DONE;
   logic        IC_INV;
   logic        IC_INV_DONE;
   logic [31:0] INT_BUSY;
   logic [31:0] FP_BUSY;
   logic        IDLE;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [1:0] U_ALU = 2'd0;
   localparam logic [1:0] U_MEM = 2'd1;
   localparam logic [1:0] U_FPU = 2'd2;
   localparam logic [1:0] U_SYS = 2'd3;

   core_issue_ctrl dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .ID_VALID    (ID_VALID),
      .ID_READY    (ID_READY),
      .ID_UNIT     (ID_UNIT),
      .ID_FENCEI   (ID_FENCEI),
      .ID_RD_NUM   (ID_RD_NUM),
      .ID_RS1_NUM  (ID_RS1_NUM),
      .ID_RS2_NUM  (ID_RS2_NUM),
      .ID_RDVALID  (ID_RDVALID),
      .ID_FRDVALID (ID_FRDVALID),
      .ID_USE_RS1  (ID_USE_RS1),
      .ID_USE_RS2  (ID_USE_RS2),
      .ID_RS1_F    (ID_RS1_F),
      .ID_RS2_F    (ID_RS2_F),
      .ISSUE_ALU   (ISSUE_ALU),
      .ISSUE_MEM   (ISSUE_MEM),
      .ISSUE_FPU   (ISSUE_FPU),
      .ISSUE_SYS   (ISSUE_SYS),
      .MEM_DONE    (MEM_DONE),
      .FPU_DONE    (FPU_DONE),
      .IC_INV      (IC_INV),
      .IC_INV_DONE (IC_INV_DONE),
      .INT_BUSY    (INT_BUSY),
      .FP_BUSY     (FP_BUSY),
      .IDLE        (IDLE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic id_idle();
      ID_VALID    = 1'b0;
      ID_UNIT     = U_ALU;
      ID_FENCEI   = 1'b0;
      ID_RD_NUM   = '0;
      ID_RS1_NUM  = '0;
      ID_RS2_NUM  = '0;
      ID_RDVALID  = 1'b0;
      ID_FRDVALID = 1'b0;
      ID_USE_RS1  = 1'b0;
      ID_USE_RS2  = 1'b0;
      ID_RS1_F    = 1'b0;
      ID_RS2_F    = 1'b0;
   endtask

   // Present one decoded instruction: unit, fence.i, rd, rs1, rs2, rd kind, source use/files.
   task automatic id_drive(input logic [1:0] unit, input logic fencei,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic rdv, input logic frdv,
                           input logic u1, input logic u2, input logic f1, input logic f2);
      ID_VALID    = 1'b1;
      ID_UNIT     = unit;
      ID_FENCEI   = fencei;
      ID_RD_NUM   = rd;
      ID_RS1_NUM  = rs1;
      ID_RS2_NUM  = rs2;
      ID_RDVALID  = rdv;
      ID_FRDVALID = frdv;
      ID_USE_RS1  = u1;
      ID_USE_RS2  = u2;
      ID_RS1_F    = f1;
      ID_RS2_F    = f2;
   endtask

   initial begin
      RST_N       = 1'b0;
      MEM_DONE    = 1'b0;
      FPU_DONE    = 1'b0;
      IC_INV_DONE = 1'b0;
      id_idle();
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      settle();

      // Reset state
      chk("rst_int_busy", INT_BUSY, 32'h0);
      chk("rst_fp_busy", FP_BUSY, 32'h0);
      chk("rst_ic_inv", {31'd0, IC_INV}, 32'h0);
      chk("rst_idle", {31'd0, IDLE}, 32'h1);
      chk("rst_issue", {28'd0, ISSUE_ALU, ISSUE_MEM, ISSUE_FPU, ISSUE_SYS}, 32'h0);
      chk("rst_ready", {31'd0, ID_READY}, 32'h1);

      // RAW stall: load x5, then ALU reading x5
      step();
      id_drive(U_MEM, 1'b0, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk("raw_issue_mem", {31'd0, ISSUE_MEM}, 32'h1);
      step();
      id_drive(U_ALU, 1'b0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk("raw_int_busy", INT_BUSY, 32'h0000_0020);
      chk("raw_stall_ready", {31'd0, ID_READY}, 32'h0);
      chk("raw_stall_issue", {31'd0, ISSUE_ALU}, 32'h0);
      chk("raw_idle_busy", {31'd0, IDLE}, 32'h0);
      step();
      chk("raw_stall_ready2", {31'd0, ID_READY}, 32'h0);
      MEM_DONE = 1'b1;
      settle();
      chk("raw_bypass_ready", {31'd0, ID_READY}, 32'h1);
      chk("raw_bypass_issue", {31'd0, ISSUE_ALU}, 32'h1);
      step();
      MEM_DONE = 1'b0;
      id_idle();
      settle();
      chk("raw_busy_clear", INT_BUSY, 32'h0);
      chk("raw_idle", {31'd0, IDLE}, 32'h1);

      // Cross-file: FPU op to f3 pending; ALU reading x3 is free
      id_drive(U_FPU, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("xf_issue_fpu", {31'd0, ISSUE_FPU}, 32'h1);
      step();
      id_drive(U_ALU, 1'b0, 5'd7, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk("xf_fp_busy", FP_BUSY, 32'h0000_0008);
      chk("xf_int_busy", INT_BUSY, 32'h0);
      chk("xf_alu_issue", {31'd0, ISSUE_ALU}, 32'h1);
      step();
      id_drive(U_MEM, 1'b0, 5'd0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      settle();
      chk("xf_fsrc_stall", {31'd0, ID_READY}, 32'h0);
      step();
      id_drive(U_FPU, 1'b0, 5'd4, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      settle();
      chk("xf_fpu_stall", {31'd0, ID_READY}, 32'h0);
      id_drive(U_MEM, 1'b0, 5'd0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      FPU_DONE = 1'b1;
      settle();
      chk("xf_fdone_issue", {31'd0, ISSUE_MEM}, 32'h1);
      step();
      FPU_DONE = 1'b0;
      id_idle();
      settle();
      chk("xf_fp_clear", FP_BUSY, 32'h0);
      chk("xf_store_nobusy", INT_BUSY, 32'h0);
      MEM_DONE = 1'b1;
      step();
      MEM_DONE = 1'b0;
      settle();
      chk("xf_idle", {31'd0, IDLE}, 32'h1);

      // Spurious DONE with empty slots is ignored
      FPU_DONE = 1'b1;
      MEM_DONE = 1'b1;
      step();
      FPU_DONE = 1'b0;
      MEM_DONE = 1'b0;
      settle();
      chk("spur_idle", {31'd0, IDLE}, 32'h1);

      // x0 destination is never tracked
      id_drive(U_MEM, 1'b0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk("x0_issue_mem", {31'd0, ISSUE_MEM}, 32'h1);
      step();
      id_drive(U_ALU, 1'b0, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk("x0_int_busy", INT_BUSY, 32'h0);
      chk("x0_alu_issue", {31'd0, ISSUE_ALU}, 32'h1);
      chk("x0_not_idle", {31'd0, IDLE}, 32'h0);
      step();
      id_drive(U_MEM, 1'b0, 5'd10, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      settle();
      chk("x0_mem_struct", {31'd0, ID_READY}, 32'h0);
      MEM_DONE = 1'b1;
      settle();
      chk("b2b_mem_issue", {31'd0, ISSUE_MEM}, 32'h1);
      step();
      MEM_DONE = 1'b0;
      // WAW on x10 held by the new load
      id_drive(U_ALU, 1'b0, 5'd10, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      chk("waw_int_busy", INT_BUSY, 32'h0000_0400);
      chk("waw_stall", {31'd0, ID_READY}, 32'h0);
      id_idle();
      MEM_DONE = 1'b1;
      step();
      MEM_DONE = 1'b0;
      settle();
      chk("waw_clear", INT_BUSY, 32'h0);

      // Structural: FPU f1 then FPU f2; issue with simultaneous DONE
      id_drive(U_FPU, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      id_drive(U_FPU, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("str_fp_busy", FP_BUSY, 32'h0000_0002);
      chk("str_stall", {31'd0, ID_READY}, 32'h0);
      step();
      chk("str_stall2", {31'd0, ISSUE_FPU}, 32'h0);
      FPU_DONE = 1'b1;
      settle();
      chk("str_issue", {31'd0, ISSUE_FPU}, 32'h1);
      step();
      FPU_DONE = 1'b0;
      id_idle();
      settle();
      chk("str_fp_busy_new", FP_BUSY, 32'h0000_0004);

      // Both slots complete in the same cycle
      id_drive(U_MEM, 1'b0, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      FPU_DONE = 1'b1;
      step();
      FPU_DONE = 1'b0;
      id_drive(U_FPU, 1'b0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      id_idle();
      settle();
      chk("dual_int_busy", INT_BUSY, 32'h0000_0800);
      chk("dual_fp_busy", FP_BUSY, 32'h0000_1000);
      MEM_DONE = 1'b1;
      FPU_DONE = 1'b1;
      step();
      MEM_DONE = 1'b0;
      FPU_DONE = 1'b0;
      settle();
      chk("dual_clear", INT_BUSY | FP_BUSY, 32'h0);
      chk("dual_idle", {31'd0, IDLE}, 32'h1);

      // Fence.i drain with MEM and FPU pending
      id_drive(U_MEM, 1'b0, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      id_drive(U_FPU, 1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      id_drive(U_SYS, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("fi_busy", {INT_BUSY[15:0], FP_BUSY[15:0]}, 32'h0100_0200);
      chk("fi_run_stall", {31'd0, ID_READY}, 32'h0);
      step();
      chk("fi_drain_stall", {31'd0, ID_READY}, 32'h0);
      MEM_DONE = 1'b1;
      settle();
      chk("fi_drain_memdone", {31'd0, ISSUE_SYS}, 32'h0);
      step();
      MEM_DONE = 1'b0;
      FPU_DONE = 1'b1;
      settle();
      chk("fi_drain_ready", {31'd0, ID_READY}, 32'h1);
      chk("fi_issue_sys", {31'd0, ISSUE_SYS}, 32'h1);
      step();
      FPU_DONE = 1'b0;
      id_drive(U_ALU, 1'b0, 5'd13, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("fi_sync_inv1", {31'd0, IC_INV}, 32'h1);
      chk("fi_sync_ready", {31'd0, ID_READY}, 32'h0);
      chk("fi_sync_sys_low", {31'd0, ISSUE_SYS}, 32'h0);
      step();
      chk("fi_sync_inv2", {31'd0, IC_INV}, 32'h1);
      step();
      IC_INV_DONE = 1'b1;
      settle();
      chk("fi_sync_inv3", {31'd0, IC_INV}, 32'h1);
      chk("fi_sync_done_rdy", {31'd0, ID_READY}, 32'h0);
      step();
      IC_INV_DONE = 1'b0;
      settle();
      chk("fi_run_inv", {31'd0, IC_INV}, 32'h0);
      chk("fi_next_issue", {31'd0, ISSUE_ALU}, 32'h1);
      step();
      id_idle();

      // Plain fence with nothing pending issues at once and stays in RUN
      id_drive(U_SYS, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("fence_issue", {31'd0, ISSUE_SYS}, 32'h1);
      step();
      id_idle();
      settle();
      chk("fence_inv", {31'd0, IC_INV}, 32'h0);
      chk("fence_idle", {31'd0, IDLE}, 32'h1);

      // Reset with an op pending
      id_drive(U_MEM, 1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      id_idle();
      settle();
      chk("rstp_busy", INT_BUSY, 32'h0000_0010);
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
      settle();
      chk("rstp_busy_clr", INT_BUSY, 32'h0);
      chk("rstp_idle", {31'd0, IDLE}, 32'h1);

      // Reset while in SYNC
      id_drive(U_SYS, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      chk("rsts_issue", {31'd0, ISSUE_SYS}, 32'h1);
      step();
      id_idle();
      settle();
      chk("rsts_inv", {31'd0, IC_INV}, 32'h1);
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
      settle();
      chk("rsts_inv_clr", {31'd0, IC_INV}, 32'h0);
      chk("rsts_busy", INT_BUSY | FP_BUSY, 32'h0);
      chk("rsts_idle", {31'd0, IDLE}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
